// File: rtl/wb_pkg.sv
// Shared Wishbone B4 classic types and widths for the bus interconnect blocks.
// Request/response bundles let the arbiter and decoder mux whole transactions at once.
package wb_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   typedef struct packed {
      logic                cyc;
      logic                stb;
      logic                we;
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
      logic [WB_SEL_W-1:0] sel;
   } wb_req_t;

   typedef struct packed {
      logic                ack;
      logic                err;
      logic [WB_DAT_W-1:0] dat;
   } wb_rsp_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: returns the first requester after lastIdx, wrapping.
// Kept free of any bus knowledge so it can be reused for other channel arbiters.
module wb_rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Offsets 1..N so the previous winner is considered last.
   always_comb begin
      int cand;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int off = 1; off <= N; off++) begin
         cand = (int'(last_i) + off) % N;
         if (!valid_o && req_i[IDX_W'(cand)]) begin
            valid_o               = 1'b1;
            idx_o                 = IDX_W'(cand);
            gnt_o[IDX_W'(cand)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Many-to-one Wishbone classic arbiter with round-robin grant held for the whole cyc
// tenure and a watchdog that turns a hung slave access into err for the stalled master.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_MASTERS-1:0]          m_cyc_i,
   input  logic [NUM_MASTERS-1:0]          m_stb_i,
   input  logic [NUM_MASTERS-1:0]          m_we_i,
   input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
   input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
   input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
   output logic [WB_DAT_W-1:0]             m_dat_o,
   output logic [NUM_MASTERS-1:0]          m_ack_o,
   output logic [NUM_MASTERS-1:0]          m_err_o,
   output logic                            s_cyc_o,
   output logic                            s_stb_o,
   output logic                            s_we_o,
   output logic [WB_ADR_W-1:0]             s_adr_o,
   output logic [WB_DAT_W-1:0]             s_dat_o,
   output logic [WB_SEL_W-1:0]             s_sel_o,
   input  logic                            s_ack_i,
   input  logic                            s_err_i,
   input  logic [WB_DAT_W-1:0]             s_dat_i,
   output logic [NUM_MASTERS-1:0]          gnt_o
);

   localparam int              IDX_W    = $clog2(NUM_MASTERS);
   localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYCLES);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [TO_W-1:0]        wdCnt_q, wdCnt_d;

   wb_req_t                mReq [NUM_MASTERS];
   wb_req_t                selReq;
   wb_rsp_t                sRsp;
   logic [NUM_MASTERS-1:0] pickGnt;
   logic [IDX_W-1:0]       pickIdx;
   logic                   pickValid;
   logic                   busy;
   logic                   reqStb;
   logic                   timeout;
   logic                   fwdAck;
   logic                   fwdErr;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign mReq[i] = '{cyc: m_cyc_i[i],
                         stb: m_stb_i[i],
                         we:  m_we_i[i],
                         adr: m_adr_i[WB_ADR_W*i +: WB_ADR_W],
                         dat: m_dat_i[WB_DAT_W*i +: WB_DAT_W],
                         sel: m_sel_i[WB_SEL_W*i +: WB_SEL_W]};
   end

   assign sRsp = '{ack: s_ack_i, err: s_err_i, dat: s_dat_i};

   // last_q always holds the current owner while BUSY, so it doubles as the mux select.
   assign selReq = mReq[last_q];

   wb_rr_arbiter #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (m_cyc_i),
      .last_i  (last_q),
      .gnt_o   (pickGnt),
      .idx_o   (pickIdx),
      .valid_o (pickValid)
   );

   // A slave ack in the timeout cycle wins, so the watchdog only fires on a truly silent slave.
   always_comb begin
      busy    = (state_q == ARB_BUSY);
      reqStb  = busy && selReq.cyc && selReq.stb;
      timeout = WD_EN && reqStb && !sRsp.ack && !sRsp.err && (wdCnt_q == WD_LIMIT);
      fwdAck  = reqStb && sRsp.ack;
      fwdErr  = (reqStb && sRsp.err) || timeout;
   end

   always_comb begin
      s_cyc_o = busy && selReq.cyc;
      s_stb_o = busy && selReq.stb && !timeout;
      s_we_o  = busy && selReq.we;
      s_adr_o = busy ? selReq.adr : '0;
      s_dat_o = busy ? selReq.dat : '0;
      s_sel_o = busy ? selReq.sel : '0;
      m_ack_o = fwdAck ? gnt_q : '0;
      m_err_o = fwdErr ? gnt_q : '0;
      m_dat_o = sRsp.dat;
      gnt_o   = gnt_q;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wdCnt_d = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (pickValid) begin
               state_d = ARB_BUSY;
               gnt_d   = pickGnt;
               last_d  = pickIdx;
            end
         end
         ARB_BUSY: begin
            if (!selReq.cyc) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
            end else if (WD_EN && reqStb && !sRsp.ack && !sRsp.err && !timeout) begin
               wdCnt_d = wdCnt_q + TO_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Reset leaves the last winner at the top index so master 0 is first after release.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         last_q  <= IDX_W'(NUM_MASTERS - 1);
         wdCnt_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wdCnt_q <= wdCnt_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed tenures, watchdog and reset cases, then
// randomized masters and slave checked against a tenure-level reference model.
module tb_wb_arbiter;

   localparam int N = 3;
   localparam int T = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
   logic [N*32-1:0]   m_adr_i, m_dat_i;
   logic [N*4-1:0]    m_sel_i;
   logic [31:0]       m_dat_o;
   logic [N-1:0]      m_ack_o, m_err_o, gnt_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [31:0]       s_adr_o, s_dat_o;
   logic [3:0]        s_sel_o;
   logic              s_ack_i, s_err_i;
   logic [31:0]       s_dat_i;

   always #5 clk_i = ~clk_i;

   wb_arbiter #(
      .NUM_MASTERS    (N),
      .TIMEOUT_CYCLES (T),
      .TO_W           (8)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .m_cyc_i (m_cyc_i),
      .m_stb_i (m_stb_i),
      .m_we_i  (m_we_i),
      .m_adr_i (m_adr_i),
      .m_dat_i (m_dat_i),
      .m_sel_i (m_sel_i),
      .m_dat_o (m_dat_o),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_we_o  (s_we_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_sel_o (s_sel_o),
      .s_ack_i (s_ack_i),
      .s_err_i (s_err_i),
      .s_dat_i (s_dat_i),
      .gnt_o   (gnt_o)
   );

   logic        cycV [N];
   logic        stbV [N];
   logic        weV  [N];
   logic [31:0] adrV [N];
   logic [31:0] datV [N];
   logic [3:0]  selV [N];
   int          beats [N];
   logic        sAck, sErr;
   logic [31:0] sDat;

   typedef struct {
      logic [N-1:0] gnt, ack, err;
      logic         cyc, stb, we;
      logic [31:0]  adr, wdat, rdat;
      logic [3:0]   sel;
   } exp_t;

   exp_t         expQ [$];
   exp_t         monExp;
   int           checks = 0;
   int           errors = 0;

   // Reference model: who owns the bus, who won last, how long the current strobe has waited.
   bit           mBusy;
   int           mG, mLast, mWd;
   logic [N-1:0] lastResp;

   bit           trackStarve = 1'b0;
   int           waitCnt [N];
   logic [N-1:0] prevGnt = '0;
   logic [N-1:0] prevCyc = '0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic bit modelTimeout();
      return mBusy && (T != 0) && cycV[mG] && stbV[mG] && !sAck && !sErr && (mWd == T);
   endfunction

   task automatic modelReset();
      mBusy = 1'b0;
      mG    = 0;
      mLast = N - 1;
      mWd   = 0;
   endtask

   task automatic modelAdvance();
      bit to;
      bit found;
      to    = modelTimeout();
      found = 1'b0;
      if (!mBusy) begin
         for (int k = 1; k <= N; k++) begin
            if (!found && cycV[(mLast + k) % N]) begin
               found = 1'b1;
               mG    = (mLast + k) % N;
            end
         end
         if (found) begin
            mBusy = 1'b1;
            mLast = mG;
            mWd   = 0;
         end
      end else if (!cycV[mG]) begin
         mBusy = 1'b0;
         mWd   = 0;
      end else begin
         mWd = ((T != 0) && stbV[mG] && !sAck && !sErr && !to) ? mWd + 1 : 0;
      end
   endtask

   task automatic drivePorts();
      for (int i = 0; i < N; i++) begin
         m_cyc_i[i]          = cycV[i];
         m_stb_i[i]          = stbV[i];
         m_we_i[i]           = weV[i];
         m_adr_i[32*i +: 32] = adrV[i];
         m_dat_i[32*i +: 32] = datV[i];
         m_sel_i[4*i +: 4]   = selV[i];
      end
      s_ack_i = sAck;
      s_err_i = sErr;
      s_dat_i = sDat;
   endtask

   // Drive this cycle's inputs and queue what the bus should show for them.
   task automatic applyStimulus();
      exp_t e;
      bit   to;
      bit   reqStb;
      drivePorts();
      to     = modelTimeout();
      e.gnt  = '0;
      e.ack  = '0;
      e.err  = '0;
      e.cyc  = 1'b0;
      e.stb  = 1'b0;
      e.we   = 1'b0;
      e.adr  = '0;
      e.wdat = '0;
      e.sel  = '0;
      e.rdat = sDat;
      if (mBusy) begin
         reqStb = cycV[mG] && stbV[mG];
         e.gnt  = N'(1) << mG;
         e.cyc  = cycV[mG];
         e.stb  = stbV[mG] && !to;
         e.we   = weV[mG];
         e.adr  = adrV[mG];
         e.wdat = datV[mG];
         e.sel  = selV[mG];
         if (reqStb && sAck) e.ack = N'(1) << mG;
         if ((reqStb && sErr) || to) e.err = N'(1) << mG;
      end
      lastResp = e.ack | e.err;
      expQ.push_back(e);
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      modelAdvance();
      #1;
   endtask

   task automatic idleInputs();
      for (int i = 0; i < N; i++) begin
         cycV[i] = 1'b0;
         stbV[i] = 1'b0;
         weV[i]  = 1'b0;
         adrV[i] = '0;
         datV[i] = '0;
         selV[i] = '0;
         beats[i] = 0;
      end
      sAck = 1'b0;
      sErr = 1'b0;
      sDat = '0;
   endtask

   task automatic newBeat(int i);
      adrV[i] = $urandom & 32'hFFFF_FFFC;
      datV[i] = $urandom;
      weV[i]  = 1'($urandom_range(0, 1));
      selV[i] = 4'($urandom);
   endtask

   task automatic randomMasters(int cycleIdx);
      bit slow;
      for (int i = 0; i < N; i++) begin
         if (cycV[i]) begin
            if (lastResp[i]) begin
               beats[i]--;
               if (beats[i] <= 0) begin
                  cycV[i] = 1'b0;
                  stbV[i] = 1'b0;
               end else begin
                  newBeat(i);
                  stbV[i] = ($urandom_range(0, 3) != 0);
               end
            end else if (!(mBusy && mG == i) && $urandom_range(0, 29) == 0) begin
               cycV[i] = 1'b0;
               stbV[i] = 1'b0;
            end else if (!stbV[i]) begin
               stbV[i] = ($urandom_range(0, 3) != 0);
            end
         end else if ($urandom_range(0, 5) == 0) begin
            cycV[i]  = 1'b1;
            beats[i] = 1 + $urandom_range(0, 3);
            newBeat(i);
            stbV[i]  = ($urandom_range(0, 3) != 0);
         end
      end
      slow = (cycleIdx % 300) >= 260;
      sAck = !slow && ($urandom_range(0, 2) == 0);
      sErr = !slow && !sAck && ($urandom_range(0, 29) == 0);
      sDat = $urandom;
   endtask

   task automatic checkOutput(exp_t e);
      check("gnt",   32'(gnt_o),   32'(e.gnt));
      check("m_ack", 32'(m_ack_o), 32'(e.ack));
      check("m_err", 32'(m_err_o), 32'(e.err));
      check("s_cyc", 32'(s_cyc_o), 32'(e.cyc));
      check("s_stb", 32'(s_stb_o), 32'(e.stb));
      check("s_we",  32'(s_we_o),  32'(e.we));
      check("s_adr", s_adr_o,      e.adr);
      check("s_dat", s_dat_o,      e.wdat);
      check("s_sel", 32'(s_sel_o), 32'(e.sel));
      check("m_dat", m_dat_o,      e.rdat);
      check("ack_onehot", 32'($countones(m_ack_o) <= 1), 32'(1));
      check("ack_to_nongranted", 32'(m_ack_o & ~gnt_o), 32'(0));
   endtask

   // Monitor: compares whenever a cycle's expectation is pending, and tracks waiting tenures.
   always @(negedge clk_i) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         checkOutput(monExp);
      end
      if (trackStarve) begin
         if (gnt_o != '0 && prevGnt == '0) begin
            for (int i = 0; i < N; i++) begin
               if (!gnt_o[i] && prevCyc[i] && m_cyc_i[i]) begin
                  waitCnt[i]++;
                  check("starve_wait", 32'(waitCnt[i] <= N - 1), 32'(1));
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!m_cyc_i[i] || gnt_o[i]) waitCnt[i] = 0;
         end
      end
      prevGnt = gnt_o;
      prevCyc = m_cyc_i;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL sim_time_limit: got no finish expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      for (int i = 0; i < N; i++) waitCnt[i] = 0;
      lastResp = '0;
      idleInputs();
      modelReset();

      // Reset state, with a request present that must be ignored.
      cycV[0] = 1'b1;
      stbV[0] = 1'b1;
      sDat    = 32'hCAFE_F00D;
      drivePorts();
      #2;
      check("rst_gnt",   32'(gnt_o),   32'(0));
      check("rst_s_cyc", 32'(s_cyc_o), 32'(0));
      check("rst_s_stb", 32'(s_stb_o), 32'(0));
      check("rst_m_ack", 32'(m_ack_o), 32'(0));
      check("rst_m_err", 32'(m_err_o), 32'(0));
      check("rst_m_dat", m_dat_o,      32'hCAFE_F00D);
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_hold_gnt", 32'(gnt_o), 32'(0));
      idleInputs();
      drivePorts();
      @(negedge clk_i);
      rst_ni = 1'b1;
      nextCycle();

      // All three request together: grants in order 0, 1, 2 with an idle cycle between.
      cycV[0] = 1'b1; cycV[1] = 1'b1; cycV[2] = 1'b1;
      applyStimulus();
      nextCycle(); applyStimulus();
      @(negedge clk_i); check("s1_first_gnt", 32'(gnt_o), 32'b001);
      nextCycle(); cycV[0] = 1'b0; applyStimulus();
      nextCycle(); applyStimulus();
      @(negedge clk_i); check("s1_idle_gap", 32'(gnt_o), 32'b000);
      nextCycle(); applyStimulus();
      @(negedge clk_i); check("s1_second_gnt", 32'(gnt_o), 32'b010);
      nextCycle(); cycV[1] = 1'b0; applyStimulus();
      nextCycle(); applyStimulus();
      nextCycle(); applyStimulus();
      @(negedge clk_i); check("s1_third_gnt", 32'(gnt_o), 32'b100);
      nextCycle(); cycV[2] = 1'b0; applyStimulus();
      nextCycle(); applyStimulus();

      // Master 1 holds four reads while master 0 waits; stray acks in stb gaps are dropped.
      nextCycle(); cycV[1] = 1'b1; applyStimulus();
      nextCycle(); cycV[0] = 1'b1; applyStimulus();
      for (int k = 0; k < 4; k++) begin
         nextCycle();
         stbV[1] = 1'b1; weV[1] = 1'b0; adrV[1] = 32'h1000 + 32'(4 * k);
         sAck = 1'b1; sDat = 32'hD000_0000 + 32'(k);
         applyStimulus();
         @(negedge clk_i);
         check("s2_ack",  32'(m_ack_o), 32'b010);
         check("s2_rdat", m_dat_o, 32'hD000_0000 + 32'(k));
         check("s2_adr",  s_adr_o, 32'h1000 + 32'(4 * k));
         nextCycle(); stbV[1] = 1'b0; applyStimulus();
         @(negedge clk_i);
         check("s2_stray_ack", 32'(m_ack_o), 32'b000);
      end
      nextCycle(); sAck = 1'b0; cycV[1] = 1'b0; applyStimulus();
      nextCycle(); applyStimulus();
      nextCycle(); applyStimulus();
      @(negedge clk_i); check("s2_m0_after", 32'(gnt_o), 32'b001);

      // Silent slave: err pulse four cycles after stb rises, stb suppressed that cycle.
      for (int k = 0; k < 7; k++) begin
         nextCycle(); stbV[0] = 1'b1; adrV[0] = 32'h2000; applyStimulus();
         @(negedge clk_i);
         check("s3_err",   32'(m_err_o), (k == 4) ? 32'b001 : 32'b000);
         check("s3_s_stb", 32'(s_stb_o), (k == 4) ? 32'd0 : 32'd1);
         check("s3_no_ack", 32'(m_ack_o), 32'b000);
      end
      nextCycle(); cycV[0] = 1'b0; stbV[0] = 1'b0; applyStimulus();
      nextCycle(); applyStimulus();

      // Ack arriving in the would-be timeout cycle wins.
      nextCycle(); cycV[1] = 1'b1; applyStimulus();
      for (int k = 0; k < 5; k++) begin
         nextCycle(); stbV[1] = 1'b1; sAck = (k == 4); applyStimulus();
         @(negedge clk_i);
         if (k == 4) begin
            check("s4_ack", 32'(m_ack_o), 32'b010);
            check("s4_err", 32'(m_err_o), 32'b000);
         end
      end
      nextCycle(); sAck = 1'b0; stbV[1] = 1'b0; cycV[1] = 1'b0; applyStimulus();
      nextCycle(); applyStimulus();

      // Reset in the middle of a master 2 write drops the bus without a clock edge.
      nextCycle(); cycV[2] = 1'b1; applyStimulus();
      nextCycle();
      stbV[2] = 1'b1; weV[2] = 1'b1; adrV[2] = 32'h3000; datV[2] = 32'h5A5A_1234; selV[2] = 4'hF;
      applyStimulus();
      @(negedge clk_i);
      check("s5_write_cyc", 32'(s_cyc_o), 32'd1);
      @(posedge clk_i);
      modelAdvance();
      #2;
      rst_ni = 1'b0;
      #1;
      check("s5_async_cyc", 32'(s_cyc_o), 32'd0);
      check("s5_async_stb", 32'(s_stb_o), 32'd0);
      check("s5_async_gnt", 32'(gnt_o),   32'd0);
      modelReset();
      @(posedge clk_i);
      #1;
      idleInputs();
      cycV[0] = 1'b1; cycV[2] = 1'b1;
      drivePorts();
      @(negedge clk_i);
      rst_ni = 1'b1;
      nextCycle(); applyStimulus();
      @(negedge clk_i); check("s5_prio0", 32'(gnt_o), 32'b001);
      nextCycle(); idleInputs(); applyStimulus();
      nextCycle(); applyStimulus();

      // Randomized traffic against the reference model.
      trackStarve = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         nextCycle();
         randomMasters(c);
         applyStimulus();
      end
      trackStarve = 1'b0;
      nextCycle(); idleInputs(); applyStimulus();
      repeat (3) begin
         nextCycle(); applyStimulus();
      end
      @(negedge clk_i);
      #1;
      check("queue_drained", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
